// File: rtl/nf10_rx_len_tagger.sv
// nf10_rx_len_tagger
// Store-and-forward receive stage for a 10G port's AXI-Stream output.
// Each packet is buffered whole while its byte count is accumulated from
// tstrb. When the packet leaves, its first beat carries the length in
// tuser[15:0] and the source-port code in tuser[23:16]. Packets that do not
// fit, or that run past C_MAX_PKT_WORDS beats, are discarded whole and
// counted. The upstream port is never backpressured.
//
// Ports:
//   axi_aclk, axi_reset        clock, synchronous active-high reset
//   s_axis_*                   input stream (tuser ignored, tready = !reset)
//   m_axis_*                   output stream, metadata on the first beat
//   pkt_count, drop_count      committed / dropped packet counters (wrapping)
module nf10_rx_len_tagger #(
  parameter int          C_AXIS_DATA_WIDTH  = 64,
  parameter int          C_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  C_SRC_PORT         = 8'h01,
  parameter int          C_FIFO_DEPTH_LOG2  = 9,
  parameter int          C_META_DEPTH_LOG2  = 4,
  parameter int          C_MAX_PKT_WORDS    = 200
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   drop_count
);

  localparam int DW         = C_AXIS_DATA_WIDTH;
  localparam int STRB_W     = C_AXIS_DATA_WIDTH / 8;
  localparam int WORD_W     = DW + STRB_W + 1;
  localparam int DEPTH      = 1 << C_FIFO_DEPTH_LOG2;
  localparam int PTR_W      = C_FIFO_DEPTH_LOG2 + 1;
  localparam int META_DEPTH = 1 << C_META_DEPTH_LOG2;
  localparam int MPTR_W     = C_META_DEPTH_LOG2 + 1;

  localparam logic [1:0] IN_IDLE   = 2'd0;
  localparam logic [1:0] IN_ACCEPT = 2'd1;
  localparam logic [1:0] IN_DROP   = 2'd2;
  localparam logic [0:0] OUT_IDLE  = 1'b0;
  localparam logic [0:0] OUT_SEND  = 1'b1;

  function automatic logic [15:0] strb_bytes(input logic [STRB_W-1:0] s);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) n = n + 16'(s[i]);
    return n;
  endfunction

  logic [WORD_W-1:0] pkt_mem  [DEPTH];
  logic [15:0]       meta_mem [META_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, wr_commit, rd_ptr, free;
  logic [MPTR_W-1:0] meta_wp, meta_rp;
  logic [1:0]        in_state, in_nxt;
  logic [0:0]        out_state;
  logic [15:0]       beat_cnt, len_acc, byte_cnt, commit_len;
  logic              beat_in, sop_ok, meta_full, meta_empty;
  logic              do_write, do_commit, do_rollback, do_drop;
  logic              load_first, load_next, go_idle, out_fire;
  logic [WORD_W-1:0] rd_word;
  logic [C_AXIS_TUSER_WIDTH-1:0] first_user;

  logic [DW-1:0]     data_p0;
  logic [STRB_W-1:0] strb_p0;
  logic [C_AXIS_TUSER_WIDTH-1:0] user_p0;
  logic              last_p0, vld_p0;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign s_axis_tready = !axi_reset;
  assign beat_in       = s_axis_tvalid && !axi_reset;
  assign byte_cnt      = strb_bytes(s_axis_tstrb);
  // Free space uses the registered rd_ptr; words read this cycle free up next cycle.
  assign free          = PTR_W'(DEPTH) - (wr_ptr - rd_ptr);
  assign meta_full     = (meta_wp - meta_rp) == MPTR_W'(META_DEPTH);
  assign meta_empty    = (meta_wp == meta_rp);
  assign sop_ok        = (32'(free) >= 32'(C_MAX_PKT_WORDS)) && !meta_full;

  // ---- input stage: classify beat, decide write / commit / drop ----
  always_comb begin
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    do_drop     = 1'b0;
    in_nxt      = in_state;
    commit_len  = len_acc + byte_cnt;
    case (in_state)
      IN_IDLE: if (beat_in) begin
        if (sop_ok) begin
          do_write   = 1'b1;
          commit_len = byte_cnt;
          if (s_axis_tlast) do_commit = 1'b1;
          else              in_nxt    = IN_ACCEPT;
        end else if (s_axis_tlast) begin
          do_drop = 1'b1;
        end else begin
          in_nxt = IN_DROP;
        end
      end
      IN_ACCEPT: if (beat_in) begin
        if (s_axis_tlast) begin
          do_write  = 1'b1;
          do_commit = 1'b1;
          in_nxt    = IN_IDLE;
        end else if (beat_cnt + 16'd1 == 16'(C_MAX_PKT_WORDS)) begin
          // Oversize: this beat is discarded and the partial packet unwound.
          do_rollback = 1'b1;
          in_nxt      = IN_DROP;
        end else begin
          do_write = 1'b1;
        end
      end
      IN_DROP: if (beat_in && s_axis_tlast) begin
        do_drop = 1'b1;
        in_nxt  = IN_IDLE;
      end
      default: in_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      in_state   <= IN_IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      meta_wp    <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      in_state <= in_nxt;
      if (do_rollback)   wr_ptr <= wr_commit;
      else if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_commit) begin
        wr_commit <= wr_ptr + PTR_W'(1);
        meta_wp   <= meta_wp + MPTR_W'(1);
        pkt_count <= pkt_count + 32'd1;
      end
      if (do_drop) drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (in_state == IN_IDLE) begin
      beat_cnt <= 16'd1;
      len_acc  <= byte_cnt;
    end else if (do_write) begin
      beat_cnt <= beat_cnt + 16'd1;
      len_acc  <= len_acc + byte_cnt;
    end
    if (do_write)  pkt_mem[wr_ptr[C_FIFO_DEPTH_LOG2-1:0]]   <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (do_commit) meta_mem[meta_wp[C_META_DEPTH_LOG2-1:0]] <= commit_len;
  end

  // ---- output stage p0: register holding the beat presented on m_axis ----
  assign rd_word    = pkt_mem[rd_ptr[C_FIFO_DEPTH_LOG2-1:0]];
  assign first_user = {{(C_AXIS_TUSER_WIDTH-24){1'b0}}, C_SRC_PORT,
                       meta_mem[meta_rp[C_META_DEPTH_LOG2-1:0]]};
  assign out_fire   = vld_p0 && m_axis_tready;

  always_comb begin
    load_first = 1'b0;
    load_next  = 1'b0;
    go_idle    = 1'b0;
    case (out_state)
      OUT_IDLE: load_first = !meta_empty;
      OUT_SEND: if (out_fire) begin
        if (last_p0) begin
          load_first = !meta_empty;
          go_idle    = meta_empty;
        end else begin
          load_next = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      out_state <= OUT_IDLE;
      rd_ptr    <= '0;
      meta_rp   <= '0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      data_p0   <= '0;
      strb_p0   <= '0;
      user_p0   <= '0;
    end else if (load_first || load_next) begin
      data_p0   <= rd_word[DW-1:0];
      strb_p0   <= rd_word[DW +: STRB_W];
      last_p0   <= rd_word[WORD_W-1];
      user_p0   <= load_first ? first_user : '0;
      vld_p0    <= 1'b1;
      rd_ptr    <= rd_ptr + PTR_W'(1);
      out_state <= OUT_SEND;
      if (load_first) meta_rp <= meta_rp + MPTR_W'(1);
    end else if (go_idle) begin
      vld_p0    <= 1'b0;
      out_state <= OUT_IDLE;
    end
  end

  assign m_axis_tdata  = data_p0;
  assign m_axis_tstrb  = strb_p0;
  assign m_axis_tuser  = user_p0;
  assign m_axis_tlast  = last_p0;
  assign m_axis_tvalid = vld_p0;

endmodule

// File: tb/tb_nf10_rx_len_tagger.sv
// Directed bench for nf10_rx_len_tagger: single, partial, single-beat,
// oversize, metadata-full and reset-during-output scenarios.
module tb_nf10_rx_len_tagger;

  logic         clk = 1'b0;
  logic         axi_reset;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]  pkt_count, drop_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nf10_rx_len_tagger dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   s;
    logic         l;
    logic [127:0] u;
    int           c;
  } beat_t;

  beat_t q[$];
  beat_t mon_b;

  // Capture each output beat that will handshake on the coming rising edge.
  always @(negedge clk) begin
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      mon_b.d = m_axis_tdata;
      mon_b.s = m_axis_tstrb;
      mon_b.l = m_axis_tlast;
      mon_b.u = m_axis_tuser;
      mon_b.c = cyc;
      q.push_back(mon_b);
    end
  end

  function automatic logic [63:0] pat(input int id, input int b);
    return {8'hD0, id[7:0], b[15:0], 32'hCAFE_0000 + 32'(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input int id, input int nb, input logic [7:0] ls);
    for (int b = 0; b < nb; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pat(id, b);
      s_axis_tstrb  = (b == nb - 1) ? ls : 8'hFF;
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic get_beat(output beat_t b);
    int w = 0;
    while (q.size() == 0 && w < 500) begin
      step();
      w++;
    end
    vectors++;
    assert (q.size() != 0)
    else begin
      miscompares++;
      $error("FAIL beat_timeout: observed no output beat expected one within 500 cycles");
    end
    if (q.size() != 0) b = q.pop_front();
    else begin
      b.d = '0; b.s = '0; b.l = 1'b0; b.u = '0; b.c = 0;
    end
  endtask

  // chain: first beat must directly follow the previous packet's last beat.
  task automatic check_pkt(input int id, input int nb, input logic [7:0] ls,
                           input logic [15:0] len, input bit chain);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      get_beat(b);
      chk($sformatf("p%0d_b%0d_data", id, i), 128'(b.d), 128'(pat(id, i)));
      chk($sformatf("p%0d_b%0d_strb", id, i), 128'(b.s), 128'((i == nb - 1) ? ls : 8'hFF));
      chk($sformatf("p%0d_b%0d_last", id, i), 128'(b.l), 128'(i == nb - 1));
      chk($sformatf("p%0d_b%0d_user", id, i), b.u,
          (i == 0) ? {104'b0, 8'h01, len} : 128'b0);
      if (i > 0 || chain)
        chk($sformatf("p%0d_b%0d_gap", id, i), 128'(b.c), 128'(last_cyc + 1));
      last_cyc = b.c;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed time limit expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_m_tdata",  128'(m_axis_tdata),  128'(0));
    chk("rst_m_tuser",  m_axis_tuser,        128'(0));
    chk("rst_pkt",      128'(pkt_count),     128'(0));
    chk("rst_drop",     128'(drop_count),    128'(0));
    axi_reset = 1'b0;
    #1;
    chk("post_rst_s_tready", 128'(s_axis_tready), 128'(1));
    step();

    // Single 64-byte packet: length 0x40
    m_axis_tready = 1'b1;
    send_pkt(1, 8, 8'hFF);
    check_pkt(1, 8, 8'hFF, 16'h0040, 1'b0);
    chk("t1_pkt",  128'(pkt_count),  128'(1));
    chk("t1_drop", 128'(drop_count), 128'(0));

    // 61-byte packet: 7 full beats + 5 bytes
    send_pkt(2, 8, 8'h1F);
    check_pkt(2, 8, 8'h1F, 16'h003D, 1'b0);
    chk("t2_pkt", 128'(pkt_count), 128'(2));

    // Single-beat 4-byte packet; tvalid two cycles after the input beat
    repeat (3) step();
    send_pkt(3, 1, 8'h0F);
    chk("t3_tvalid_t1", 128'(m_axis_tvalid), 128'(0));
    step();
    chk("t3_tvalid_t2", 128'(m_axis_tvalid), 128'(1));
    check_pkt(3, 1, 8'h0F, 16'h0004, 1'b0);
    chk("t3_pkt", 128'(pkt_count), 128'(3));

    // 201-beat packet dropped; write pointer back at 8+8+1 = 17 words
    repeat (3) step();
    send_pkt(4, 201, 8'hFF);
    chk("t4_drop", 128'(drop_count), 128'(1));
    chk("t4_pkt",  128'(pkt_count),  128'(3));
    repeat (5) step();
    chk("t4_no_output", 128'(q.size()), 128'(0));
    chk("t4_wr_ptr", 128'(dut.wr_ptr), 128'(17));
    send_pkt(5, 8, 8'hFF);
    check_pkt(5, 8, 8'hFF, 16'h0040, 1'b0);
    chk("t4_pkt_after", 128'(pkt_count), 128'(4));

    // Metadata full under tready=0. Packet 10 is popped into the output
    // register straight away, so the 16-entry FIFO then takes packets
    // 11..26 and packet 27 finds it full and is dropped.
    repeat (3) step();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 18; i++) send_pkt(10 + i, 8, 8'hFF);
    chk("t5_drop", 128'(drop_count), 128'(2));
    chk("t5_pkt",  128'(pkt_count),  128'(21));
    chk("t5_hold_tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("t5_hold_tdata",  128'(m_axis_tdata),  128'(pat(10, 0)));
    chk("t5_hold_tuser",  m_axis_tuser, {104'b0, 8'h01, 16'h0040});
    chk("t5_hold_tlast",  128'(m_axis_tlast),  128'(0));
    chk("t5_no_output",   128'(q.size()),      128'(0));
    m_axis_tready = 1'b1;
    for (int i = 0; i < 17; i++) check_pkt(10 + i, 8, 8'hFF, 16'h0040, i > 0);
    repeat (5) step();
    chk("t5_no_extra", 128'(q.size()), 128'(0));

    // Reset while the third output beat is presented
    send_pkt(30, 8, 8'hFF);
    w = 0;
    while (!m_axis_tvalid && w < 20) begin
      step();
      w++;
    end
    chk("t6_tvalid", 128'(m_axis_tvalid), 128'(1));
    step();
    step();
    chk("t6_beat3", 128'(m_axis_tdata), 128'(pat(30, 2)));
    axi_reset = 1'b1;
    step();
    chk("t6_tvalid_rst", 128'(m_axis_tvalid), 128'(0));
    chk("t6_tdata_rst",  128'(m_axis_tdata),  128'(0));
    chk("t6_tstrb_rst",  128'(m_axis_tstrb),  128'(0));
    chk("t6_tlast_rst",  128'(m_axis_tlast),  128'(0));
    chk("t6_tuser_rst",  m_axis_tuser,        128'(0));
    chk("t6_pkt_rst",    128'(pkt_count),     128'(0));
    chk("t6_drop_rst",   128'(drop_count),    128'(0));
    chk("t6_s_tready",   128'(s_axis_tready), 128'(0));
    axi_reset = 1'b0;
    step();
    q.delete();
    send_pkt(31, 8, 8'hFF);
    check_pkt(31, 8, 8'hFF, 16'h0040, 1'b0);
    chk("t6_pkt_after",  128'(pkt_count),  128'(1));
    chk("t6_drop_after", 128'(drop_count), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
